mem_arbiter2: RTL

- Two-requester round-robin arbiter and sequencer for the single shared memory port.
- Requester 0 is instruction fetch; requester 1 is the data access unit.
- Latches the winner's request, drives it to memory, waits for the response and routes it back to the winner.
- Exports `sel`, which drives the select of the shared 2:1 datapath multiplexers downstream.

---
 rtl/mem_arbiter2_pkg.sv | 14 +
 rtl/mem_arbiter2_if.sv | 58 +++++
 rtl/mem_arbiter2_arb_rr2.sv | 18 +
 rtl/mem_arbiter2.sv | 89 ++++++++
 4 files changed

// File: rtl/mem_arbiter2_pkg.sv
// Shared state encoding and default widths for the two-requester memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arbiter2_pkg;

  // Sequencer states; plain constants keep the encoding visible to legacy tooling.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arbiter2_if.sv
// Bundle of both requester ports, the shared memory port and the mux select.
// Latency: none (wires only).
// Backpressure: gnt per requester, m_ready on the memory side.
interface mem_arbiter2_if #(
  parameter int AW = mem_arbiter2_pkg::DEF_AW,
  parameter int DW = mem_arbiter2_pkg::DEF_DW,
  parameter int BW = DW / 8
);

  logic          req0;
  logic [AW-1:0] addr0;
  logic [BW-1:0] wen0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic [AW-1:0] addr1;
  logic [BW-1:0] wen1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic          m_req;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wen;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  logic          sel;

  // Arbiter side: consumes requests and memory responses.
  modport slave (
    input  req0, addr0, wen0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, addr1, wen1, wdata1,
    output gnt1, rvalid1, rdata1,
    output m_req, m_addr, m_wen, m_wdata,
    input  m_ready, m_rvalid, m_rdata,
    output sel
  );

  // Environment side: requesters plus the memory itself.
  modport master (
    output req0, addr0, wen0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, addr1, wen1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  m_req, m_addr, m_wen, m_wdata,
    output m_ready, m_rvalid, m_rdata,
    input  sel
  );

endinterface

// File: rtl/mem_arbiter2_arb_rr2.sv
// Two-way round-robin picker: on a tie the side that did not win last time wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic winner
);

  // A lone requester always wins; a tie goes to the opposite of the last winner.
  always_comb begin
    any    = req0 | req1;
    winner = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter/sequencer sharing one memory port between fetch (0) and data (1).
// Latency: gnt at t, m_req from t+1, response routed combinationally on m_rvalid.
// Backpressure: m_req held with a stable payload until m_ready; one transaction in flight.
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int BW = DW / 8
) (
  input logic            clk,
  input logic            rst,
  mem_arbiter2_if.slave  bus
);

  logic [1:0]    state;
  logic          owner;
  logic          last;
  logic [AW-1:0] addr_q;
  logic [BW-1:0] wen_q;
  logic [DW-1:0] wdata_q;

  logic any;
  logic winner;
  logic grant;
  logic resp;

  arb_rr2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  // Grant and response are gated by reset so outputs sit at their idle values while it is held.
  assign grant = !rst && (state == IDLE) && any;
  assign resp  = !rst && (state == WAIT) && bus.m_rvalid;

  // Sequencer: latch the winner's payload in IDLE, issue until accepted, wait for the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            owner   <= winner;
            last    <= winner;
            addr_q  <= winner ? bus.addr1  : bus.addr0;
            wen_q   <= winner ? bus.wen1   : bus.wen0;
            wdata_q <= winner ? bus.wdata1 : bus.wdata0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_ready) state <= WAIT;
        end
        WAIT: begin
          if (bus.m_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = grant & ~winner;
  assign bus.gnt1    = grant &  winner;

  assign bus.m_req   = (state == ISSUE);
  assign bus.m_addr  = addr_q;
  assign bus.m_wen   = wen_q;
  assign bus.m_wdata = wdata_q;

  // Read data fans out to both sides; only the owner's rvalid qualifies it.
  assign bus.rvalid0 = resp & ~owner;
  assign bus.rvalid1 = resp &  owner;
  assign bus.rdata0  = bus.m_rdata;
  assign bus.rdata1  = bus.m_rdata;

  // Owner register doubles as the downstream mux select; it only moves on a grant.
  assign bus.sel     = owner;

endmodule
